// File: rtl/pb_uart_tx.sv
// UART transmit stage: byte FIFO feeding an 8N1 serialiser with a programmable bit period.
// All outputs are registered; FIFO status flags follow the occupancy one cycle after a push or pop.
module pb_uart_tx #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        buffer_write,
    input  logic [7:0]  uart_data_write,
    input  logic        enable,
    input  logic [15:0] uart_clock_divide,
    output logic        tx,
    output logic        tx_data_present,
    output logic        tx_half_full,
    output logic        tx_full,
    output logic        tx_busy,
    output logic        tx_overrun
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // FIFO storage: no reset, read only through the registered shift-register load
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;

    state_t      state_reg;
    logic [15:0] div_reg;
    logic [15:0] baud_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        tx_reg;
    logic        busy_reg;

    logic present_reg;
    logic half_reg;
    logic full_reg;
    logic overrun_reg;

    logic fifo_full;
    logic fifo_empty;
    logic baud_done;
    logic push;
    logic pop;

    // Full/empty come from the pre-cycle count, so a pop never frees room for a same-cycle push
    assign fifo_full  = (count_reg == CW'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign baud_done  = (baud_reg == div_reg);
    assign push       = buffer_write && !fifo_full;
    assign pop        = enable && !fifo_empty &&
                        ((state_reg == IDLE) || ((state_reg == STOP) && baud_done));

    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= uart_data_write;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            present_reg <= 1'b0;
            half_reg    <= 1'b0;
            full_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
            end
            count_reg   <= count_next;
            present_reg <= (count_next != '0);
            half_reg    <= (count_next >= CW'(DEPTH / 2));
            full_reg    <= (count_next == CW'(DEPTH));
            overrun_reg <= buffer_write && fifo_full;
        end
    end

    // Frame sequencer; the divide value is captured at each frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        div_reg   <= uart_clock_divide;
                        baud_reg  <= '0;
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_reg    <= '0;
                        bit_idx_reg <= '0;
                        tx_reg      <= shift_reg[0];
                        state_reg   <= DATA;
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_reg <= '0;
                        if (pop) begin
                            // back-to-back frame: no idle bit between stop and next start
                            shift_reg <= mem[rd_ptr_reg];
                            div_reg   <= uart_clock_divide;
                            tx_reg    <= 1'b0;
                            state_reg <= START;
                        end else begin
                            tx_reg    <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx              = tx_reg;
    assign tx_busy         = busy_reg;
    assign tx_data_present = present_reg;
    assign tx_half_full    = half_reg;
    assign tx_full         = full_reg;
    assign tx_overrun      = overrun_reg;

endmodule

// File: tb/tb_pb_uart_tx.sv
// Testbench for pb_uart_tx: a frame-timeline reference model checked every cycle,
// a table of constant expectations for one frame, hand-written corner sequences, random traffic.
module tb_pb_uart_tx;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 2 ** DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        reset;
    logic        buffer_write;
    logic [7:0]  uart_data_write;
    logic        enable;
    logic [15:0] uart_clock_divide;
    logic        tx;
    logic        tx_data_present;
    logic        tx_half_full;
    logic        tx_full;
    logic        tx_busy;
    logic        tx_overrun;

    always #5 clk = ~clk;

    pb_uart_tx #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk               (clk),
        .reset             (reset),
        .buffer_write      (buffer_write),
        .uart_data_write   (uart_data_write),
        .enable            (enable),
        .uart_clock_divide (uart_clock_divide),
        .tx                (tx),
        .tx_data_present   (tx_data_present),
        .tx_half_full      (tx_half_full),
        .tx_full           (tx_full),
        .tx_busy           (tx_busy),
        .tx_overrun        (tx_overrun)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queued bytes plus the position inside the frame currently on the line
    byte unsigned mq[$];
    bit           m_active;
    int           m_k;
    int           m_div;
    logic [9:0]   m_frame;
    bit           m_ovr;

    typedef struct {
        logic        wr;
        logic [7:0]  data;
        logic        en;
        logic [15:0] div;
        int          cycles;
        logic        e_tx;
        logic        e_busy;
        logic        e_present;
    } vec_t;
    vec_t tbl[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_tx();
        if (!m_active) return 1'b1;
        return m_frame[m_k / (m_div + 1)];
    endfunction

    task automatic model_clear();
        mq.delete();
        m_active = 1'b0;
        m_k      = 0;
        m_div    = 0;
        m_ovr    = 1'b0;
    endtask

    task automatic set_in(input logic wr, input logic [7:0] d, input logic en, input logic [15:0] dv);
        buffer_write      = wr;
        uart_data_write   = d;
        enable            = en;
        uart_clock_divide = dv;
    endtask

    // One clock: advance the model with the current inputs, then compare every output
    task automatic tick();
        int n;
        int len;
        byte unsigned b;
        n     = mq.size();
        len   = 10 * (m_div + 1);
        m_ovr = buffer_write && (n == DEPTH);
        if (enable && n != 0 && (!m_active || m_k == len - 1)) begin
            b        = mq.pop_front();
            m_frame  = {1'b1, b, 1'b0};
            m_div    = int'(uart_clock_divide);
            m_k      = 0;
            m_active = 1'b1;
        end else if (m_active) begin
            if (m_k == len - 1) m_active = 1'b0;
            else m_k++;
        end
        if (buffer_write && n != DEPTH) mq.push_back(uart_data_write);
        @(posedge clk);
        #1;
        cmp("tx", tx, m_tx());
        cmp("tx_busy", tx_busy, m_active);
        cmp("tx_data_present", tx_data_present, mq.size() != 0);
        cmp("tx_half_full", tx_half_full, mq.size() >= DEPTH / 2);
        cmp("tx_full", tx_full, mq.size() == DEPTH);
        cmp("tx_overrun", tx_overrun, m_ovr);
    endtask

    task automatic add_row(input logic wr, input logic [7:0] d, input int cyc,
                           input logic etx, input logic ebusy, input logic epres);
        vec_t v;
        v.wr = wr; v.data = d; v.en = 1'b1; v.div = 16'd3; v.cycles = cyc;
        v.e_tx = etx; v.e_busy = ebusy; v.e_present = epres;
        tbl.push_back(v);
    endtask

    task automatic idle_until_quiet();
        set_in(1'b0, 8'h00, enable, uart_clock_divide);
        for (int g = 0; g < 2000 && (m_active || mq.size() != 0); g++) tick();
        cmp("drain_done", m_active || mq.size() != 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a5;
        logic [19:0] seq;
        logic [19:0] seq_exp;
        int          busy_cnt;

        set_in(1'b0, 8'h00, 1'b0, 16'd3);
        reset = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cmp("reset_tx", tx, 1);
        cmp("reset_busy", tx_busy, 0);
        cmp("reset_present", tx_data_present, 0);
        cmp("reset_half", tx_half_full, 0);
        cmp("reset_full", tx_full, 0);
        cmp("reset_overrun", tx_overrun, 0);
        $display("reset: outputs checked");

        // Single 0xA5 frame at div=3: constant expectations for every cycle
        a5 = 8'hA5;
        add_row(1'b1, 8'hA5, 1, 1'b1, 1'b0, 1'b1);
        add_row(1'b0, 8'h00, 4, 1'b0, 1'b1, 1'b0);
        for (int b = 0; b < 8; b++) add_row(1'b0, 8'h00, 4, a5[b], 1'b1, 1'b0);
        add_row(1'b0, 8'h00, 4, 1'b1, 1'b1, 1'b0);
        add_row(1'b0, 8'h00, 4, 1'b1, 1'b0, 1'b0);
        foreach (tbl[r]) begin
            set_in(tbl[r].wr, tbl[r].data, tbl[r].en, tbl[r].div);
            for (int c = 0; c < tbl[r].cycles; c++) begin
                tick();
                cmp("tbl_tx", tx, tbl[r].e_tx);
                cmp("tbl_busy", tx_busy, tbl[r].e_busy);
                cmp("tbl_present", tx_data_present, tbl[r].e_present);
            end
            $display("table row %0d: wr=%0d data=%02h cycles=%0d tx=%0d busy=%0d", r,
                     tbl[r].wr, tbl[r].data, tbl[r].cycles, tbl[r].e_tx, tbl[r].e_busy);
        end

        // Fill with enable low, overflow once, then drain back-to-back at div=1
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 8'(i * 17 + 3), 1'b0, 16'd1);
            tick();
            cmp("fill_half", tx_half_full, (i + 1) >= DEPTH / 2);
            cmp("fill_full", tx_full, (i + 1) == DEPTH);
        end
        set_in(1'b1, 8'hEE, 1'b0, 16'd1);
        tick();
        cmp("overrun_pulse", tx_overrun, 1);
        set_in(1'b0, 8'h00, 1'b1, 16'd1);
        busy_cnt = 0;
        for (int i = 0; i < 16 * 20; i++) begin
            tick();
            if (tx_busy) busy_cnt++;
        end
        cmp("b2b_busy_cycles", busy_cnt, 320);
        tick();
        cmp("b2b_idle_after", tx_busy, 0);
        $display("fill/overrun/drain: 16 frames at div=1");

        // div=0: 0x00 then 0xFF as 20 contiguous bit times
        set_in(1'b1, 8'h00, 1'b1, 16'd0);
        tick();
        set_in(1'b1, 8'hFF, 1'b1, 16'd0);
        seq = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seq[i] = tx;
            set_in(1'b0, 8'h00, 1'b1, 16'd0);
        end
        for (int i = 0; i < 20; i++) seq_exp[i] = (i == 9) || (i >= 11);
        cmp("div0_sequence", seq, seq_exp);
        idle_until_quiet();
        $display("div0: 0x00,0xFF sequence %05h", seq);

        // Divide change mid-frame applies only to the following frame
        set_in(1'b1, 8'h96, 1'b1, 16'd3);
        tick();
        set_in(1'b0, 8'h00, 1'b1, 16'd3);
        for (int i = 0; i < 12; i++) tick();
        set_in(1'b1, 8'h3C, 1'b1, 16'd7);
        tick();
        set_in(1'b0, 8'h00, 1'b1, 16'd7);
        idle_until_quiet();
        $display("divide change: 0x96 at div=3 then 0x3C at div=7");

        // Asynchronous reset during data bit 4 with bytes still queued
        set_in(1'b1, 8'h4B, 1'b1, 16'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 8'(8'h20 + i), 1'b1, 16'd3);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b1, 16'd3);
        for (int g = 0; g < 200 && !(m_active && m_k / 4 == 5); g++) tick();
        cmp("reach_bit4", m_active && m_k / 4 == 5, 1);
        cmp("bit4_low", tx, 0);
        #2 reset = 1'b1;
        #1;
        cmp("async_tx", tx, 1);
        cmp("async_busy", tx_busy, 0);
        cmp("async_present", tx_data_present, 0);
        cmp("async_half", tx_half_full, 0);
        cmp("async_full", tx_full, 0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        cmp("no_restart", tx_busy, 0);
        $display("mid-frame reset: line high, FIFO empty, no restart");

        // Full FIFO: push coinciding with the STOP-end pop is dropped
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 8'(i * 16 + 1), 1'b0, 16'd0);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b1, 16'd0);
        tick();
        set_in(1'b1, 8'hC7, 1'b1, 16'd0);
        tick();
        cmp("refill_full", tx_full, 1);
        set_in(1'b0, 8'h00, 1'b1, 16'd0);
        for (int g = 0; g < 50 && !(m_active && m_k == 9); g++) tick();
        cmp("reach_stop_end", m_active && m_k == 9, 1);
        set_in(1'b1, 8'h5A, 1'b1, 16'd0);
        tick();
        cmp("pushpop_overrun", tx_overrun, 1);
        cmp("pushpop_full", tx_full, 0);
        cmp("pushpop_half", tx_half_full, 1);
        set_in(1'b0, 8'h00, 1'b1, 16'd0);
        idle_until_quiet();
        $display("full push+pop: 0x5A dropped, remaining frames drained");

        // Random traffic against the model
        set_in(1'b0, 8'h00, 1'b1, 16'd1);
        for (int i = 0; i < 4000; i++) begin
            logic en_r;
            logic [15:0] dv_r;
            en_r = enable;
            dv_r = uart_clock_divide;
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            if ($urandom_range(0, 299) == 0) dv_r = 16'($urandom_range(0, 3));
            set_in($urandom_range(0, 3) == 0, 8'($urandom), en_r, dv_r);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b1, uart_clock_divide);
        idle_until_quiet();
        $display("random: 4000 cycles of mixed traffic");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
